// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with valid/ready handshakes on both sides,
// 16 operations, {N,Z,C,V} status flags and an architectural carry register
// that chains ADC/SBB across transactions. Results leave in issue order.
module alu_pipe #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             carry
);

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_NOT   = 4'd3,
        OP_OR    = 4'd4,
        OP_XOR   = 4'd5,
        OP_SHL   = 4'd6,
        OP_SHR   = 4'd7,
        OP_SRA   = 4'd8,
        OP_ROL   = 4'd9,
        OP_ROR   = 4'd10,
        OP_SLT   = 4'd11,
        OP_SLTU  = 4'd12,
        OP_ADC   = 4'd13,
        OP_SBB   = 4'd14,
        OP_PASSB = 4'd15
    } op_e;

    // Stage 1: captured operands
    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    op_e              s1_op;

    // Stage 2: registered result and flags
    logic             s2_valid;
    logic [WIDTH-1:0] s2_result;
    logic [3:0]       s2_flags;
    logic             carry_reg;

    // Handshake
    logic s2_free;
    logic s1_adv;
    logic accept;

    assign s2_free  = !s2_valid || out_ready;
    assign s1_adv   = s1_valid && s2_free;
    assign in_ready = !rst && (!s1_valid || s2_free);
    assign accept   = in_valid && in_ready;

    assign out_valid = s2_valid;
    assign result    = s2_result;
    assign flags     = s2_flags;
    assign carry     = carry_reg;

    // Datapath signals
    logic [SHW-1:0]   sh;
    logic [SHW-1:0]   neg_sh;
    logic             cin;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic             lt_signed;
    logic             lt_unsigned;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic             alu_is_arith;
    logic [3:0]       alu_flags;

    // Shared adder/subtractor inputs; carry-in only applies to ADC/SBB
    always_comb begin
        sh          = s1_b[SHW-1:0];
        // Rotates are built from two shifts; a (W - sh) mod W amount keeps
        // rotate-by-0 returning A since W is a power of two
        neg_sh      = SHW'(0) - sh;
        cin         = (s1_op == OP_ADC || s1_op == OP_SBB) ? carry_reg : 1'b0;
        sum_ext     = {1'b0, s1_a} + {1'b0, s1_b} + {{WIDTH{1'b0}}, cin};
        diff_ext    = {1'b0, s1_a} - {1'b0, s1_b} - {{WIDTH{1'b0}}, cin};
        lt_signed   = $signed(s1_a) < $signed(s1_b);
        lt_unsigned = s1_a < s1_b;
    end

    // Operation select, carry/overflow and flag packing from stage 1
    always_comb begin
        alu_res      = '0;
        alu_c        = 1'b0;
        alu_v        = 1'b0;
        alu_is_arith = 1'b0;
        case (s1_op)
            OP_ADD, OP_ADC: begin
                alu_res      = sum_ext[WIDTH-1:0];
                alu_c        = sum_ext[WIDTH];
                alu_v        = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) &&
                               (alu_res[WIDTH-1] != s1_a[WIDTH-1]);
                alu_is_arith = 1'b1;
            end
            OP_SUB, OP_SBB: begin
                alu_res      = diff_ext[WIDTH-1:0];
                alu_c        = diff_ext[WIDTH];
                alu_v        = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) &&
                               (alu_res[WIDTH-1] != s1_a[WIDTH-1]);
                alu_is_arith = 1'b1;
            end
            OP_AND:   alu_res = s1_a & s1_b;
            OP_NOT:   alu_res = ~s1_a;
            OP_OR:    alu_res = s1_a | s1_b;
            OP_XOR:   alu_res = s1_a ^ s1_b;
            OP_SHL:   alu_res = s1_a << sh;
            OP_SHR:   alu_res = s1_a >> sh;
            OP_SRA:   alu_res = $unsigned($signed(s1_a) >>> sh);
            OP_ROL:   alu_res = (s1_a << sh) | (s1_a >> neg_sh);
            OP_ROR:   alu_res = (s1_a >> sh) | (s1_a << neg_sh);
            OP_SLT:   alu_res = {{(WIDTH-1){1'b0}}, lt_signed};
            OP_SLTU:  alu_res = {{(WIDTH-1){1'b0}}, lt_unsigned};
            OP_PASSB: alu_res = s1_b;
            default:  alu_res = '0;
        endcase
        alu_flags = {alu_res[WIDTH-1], (alu_res == '0), alu_c, alu_v};
    end

    // Stage 1 capture on input handshake; empties when it advances
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= OP_ADD;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_a     <= A;
            s1_b     <= B;
            s1_op    <= op_e'(control);
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2 result register; holds while the consumer stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid  <= 1'b0;
            s2_result <= '0;
            s2_flags  <= '0;
        end else if (s1_adv) begin
            s2_valid  <= 1'b1;
            s2_result <= alu_res;
            s2_flags  <= alu_flags;
        end else if (out_ready) begin
            s2_valid  <= 1'b0;
        end
    end

    // Architectural carry follows arithmetic ops as they enter stage 2
    always_ff @(posedge clk) begin
        if (rst) begin
            carry_reg <= 1'b0;
        end else if (s1_adv && alu_is_arith) begin
            carry_reg <= alu_c;
        end
    end

endmodule
